adc_spi_reader: RTL and testbench



---
 rtl/adc_spi_pkg.sv | 24 ++
 rtl/adc_spi_sclk_gen.sv | 63 ++++++
 rtl/adc_spi_reader.sv | 186 ++++++++++++++++++
 tb/tb_adc_spi_reader.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_pkg
// Purpose  : Shared types and constants for the SPI ADC reader: FSM state
//            enum, AXI-Stream beat width and sequence-field placement.
// Ports    : none (package)
// Config   : ADC_SPI_SEQ_EN uses the sequence-field constants.
// Revision : 1.0 - initial release
// ============================================================================
package adc_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READ    = 2'd2,
    ST_STORE   = 2'd3
  } state_e;

  localparam int C_AXIS_DATA_W = 32;  // output beat width
  localparam int C_SEQ_W       = 8;   // sequence-number field width
  localparam int C_SEQ_LSB     = 24;  // sequence field occupies [31:24]

endpackage
`default_nettype wire

// File: rtl/adc_spi_sclk_gen.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_sclk_gen
// Purpose  : SCLK generator for one SPI read burst. While run_i is high it
//            toggles SCLK every CLK_DIV aclk cycles (starting low), strobes
//            sample_o on the aclk edge at which SCLK rises, and strobes done_o
//            on the edge of the final falling edge after DATA_BITS rises.
//            Dropping run_i returns everything to idle (SCLK low).
// Ports    : aclk, aresetn (async, active-low)
//            run_i    - high for the whole read phase
//            sclk_o   - registered serial clock
//            sample_o - MISO sample strobe (SCLK rising at this edge)
//            done_o   - last falling edge happens at this edge
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_sclk_gen #(
  parameter int DATA_BITS = 24,
  parameter int CLK_DIV   = 2
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic run_i,
  output logic sclk_o,
  output logic sample_o,
  output logic done_o
);

  localparam int C_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int C_BIT_W = $clog2(DATA_BITS + 1);

  logic [C_DIV_W-1:0] div_q;
  logic               sclk_q;
  logic [C_BIT_W-1:0] bit_q;    // rising edges issued so far
  logic               w_tick;   // half-period boundary

  assign w_tick   = run_i && (div_q == C_DIV_W'(CLK_DIV - 1));
  assign sample_o = w_tick && !sclk_q;
  // Falling edge after the last rise ends the burst.
  assign done_o   = w_tick && sclk_q && (bit_q == C_BIT_W'(DATA_BITS));
  assign sclk_o   = sclk_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      bit_q  <= '0;
    end else if (!run_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
      bit_q  <= '0;
    end else if (w_tick) begin
      div_q  <= '0;
      sclk_q <= !sclk_q;
      if (!sclk_q) begin
        bit_q <= bit_q + 1'b1;
      end
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_reader
// Purpose  : Trigger-driven SPI ADC acquisition. A trigger starts a fixed
//            conversion pulse, then the result is clocked in MSB first and
//            presented as one sign-extended 32-bit AXI-Stream beat through a
//            single-entry output register. A sample that cannot be stored is
//            dropped and flagged with a one-cycle overrun pulse.
// Ports    : aclk, aresetn (async, active-low)
//            enable, trigger           - trigger gating / request
//            busy, overrun             - status
//            spi_cnv, spi_cs_n, spi_sclk, spi_miso - ADC interface
//            m_axis_data_tdata/tvalid/tready       - sample stream
// Config   : ADC_SPI_SEQ_EN - tdata[31:24] carries an 8-bit sequence number
//            counting every completed conversion; needs DATA_BITS <= 24.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_reader #(
  parameter int DATA_BITS   = 24,
  parameter int CLK_DIV     = 2,
  parameter int CONV_CYCLES = 50
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        enable,
  input  logic        trigger,
  output logic        busy,
  output logic        overrun,
  output logic        spi_cnv,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  input  logic        spi_miso,
  output logic [31:0] m_axis_data_tdata,
  output logic        m_axis_data_tvalid,
  input  logic        m_axis_data_tready
);

  import adc_spi_pkg::*;

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (DATA_BITS < 8 || DATA_BITS > 32) begin : g_bad_data_bits
    $error("adc_spi_reader: DATA_BITS must be in 8..32");
  end
  if (CLK_DIV < 1) begin : g_bad_clk_div
    $error("adc_spi_reader: CLK_DIV must be >= 1");
  end
  if (CONV_CYCLES < 1) begin : g_bad_conv_cycles
    $error("adc_spi_reader: CONV_CYCLES must be >= 1");
  end
`ifdef ADC_SPI_SEQ_EN
  if (DATA_BITS > C_SEQ_LSB) begin : g_bad_seq_bits
    $error("adc_spi_reader: ADC_SPI_SEQ_EN requires DATA_BITS <= 24");
  end
`endif

  localparam logic [31:0] C_CONV_LAST = 32'(CONV_CYCLES - 1);

  state_e                      state_q;
  logic [31:0]                 conv_cnt_q;
  logic [DATA_BITS-1:0]        shift_q;
  logic                        cnv_q;
  logic                        cs_n_q;
  logic                        busy_q;
  logic                        overrun_q;
  logic                        tvalid_q;
  logic [C_AXIS_DATA_W-1:0]    tdata_q;

  logic                        w_read;
  logic                        w_sclk;
  logic                        w_sample_stb;
  logic                        w_done;
  logic signed [DATA_BITS-1:0] w_raw_s;
  logic [C_AXIS_DATA_W-1:0]    w_sext;
  logic [C_AXIS_DATA_W-1:0]    w_beat;

  assign w_read = (state_q == ST_READ);

  adc_spi_sclk_gen #(
    .DATA_BITS (DATA_BITS),
    .CLK_DIV   (CLK_DIV)
  ) u_sclk_gen (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .run_i    (w_read),
    .sclk_o   (w_sclk),
    .sample_o (w_sample_stb),
    .done_o   (w_done)
  );

  // Signed size cast replicates bit DATA_BITS-1; a no-op when DATA_BITS=32.
  assign w_raw_s = shift_q;
  assign w_sext  = C_AXIS_DATA_W'(w_raw_s);

`ifdef ADC_SPI_SEQ_EN
  logic [C_SEQ_W-1:0] seq_q;
  assign w_beat = {seq_q, w_sext[C_SEQ_LSB-1:0]};
`else
  assign w_beat = w_sext;
`endif

  // ---------------------------------------------------------------------------
  // FSM, shift register, output register and overrun flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= ST_IDLE;
      conv_cnt_q <= '0;
      shift_q    <= '0;
      cnv_q      <= 1'b0;
      cs_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
      tvalid_q   <= 1'b0;
      tdata_q    <= '0;
`ifdef ADC_SPI_SEQ_EN
      seq_q      <= '0;
`endif
    end else begin
      overrun_q <= 1'b0;

      // Handshake retires the held beat; a STORE below may refill it.
      if (tvalid_q && m_axis_data_tready) begin
        tvalid_q <= 1'b0;
      end

      if (w_sample_stb) begin
        shift_q <= {shift_q[DATA_BITS-2:0], spi_miso};
      end

      case (state_q)
        ST_IDLE: begin
          if (trigger && enable) begin
            state_q    <= ST_CONVERT;
            conv_cnt_q <= '0;
            cnv_q      <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ST_CONVERT: begin
          if (conv_cnt_q == C_CONV_LAST) begin
            state_q <= ST_READ;
            cnv_q   <= 1'b0;
            cs_n_q  <= 1'b0;
          end else begin
            conv_cnt_q <= conv_cnt_q + 32'd1;
          end
        end
        ST_READ: begin
          if (w_done) begin
            state_q <= ST_STORE;
            cs_n_q  <= 1'b1;
          end
        end
        ST_STORE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          // Load when empty or when the held beat leaves this same cycle.
          if (!tvalid_q || m_axis_data_tready) begin
            tvalid_q <= 1'b1;
            tdata_q  <= w_beat;
          end else begin
            overrun_q <= 1'b1;
          end
`ifdef ADC_SPI_SEQ_EN
          seq_q <= seq_q + 1'b1;
`endif
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy               = busy_q;
  assign overrun            = overrun_q;
  assign spi_cnv            = cnv_q;
  assign spi_cs_n           = cs_n_q;
  assign spi_sclk           = w_sclk;
  assign m_axis_data_tdata  = tdata_q;
  assign m_axis_data_tvalid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_reader
// Purpose  : Self-checking bench for adc_spi_reader with default parameters.
//            A behavioural SPI ADC model serves random words; expected beats
//            come from plain arithmetic sign extension (plus sequence number
//            when ADC_SPI_SEQ_EN is defined). Stream stability, beat count and
//            overrun pulses are tracked by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_reader;

  localparam int DATA_BITS   = 24;
  localparam int CLK_DIV     = 2;
  localparam int CONV_CYCLES = 50;
  localparam int READ_CYC    = 2 * CLK_DIV * DATA_BITS;
  localparam int LAT         = CONV_CYCLES + READ_CYC + 2;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable  = 1'b0;
  logic        trigger = 1'b0;
  logic        spi_miso = 1'b0;
  logic        tready  = 1'b0;
  logic        busy, overrun, spi_cnv, spi_cs_n, spi_sclk, tvalid;
  logic [31:0] tdata;

  always #5 aclk = ~aclk;

  adc_spi_reader #(
    .DATA_BITS   (DATA_BITS),
    .CLK_DIV     (CLK_DIV),
    .CONV_CYCLES (CONV_CYCLES)
  ) dut (
    .aclk               (aclk),
    .aresetn            (aresetn),
    .enable             (enable),
    .trigger            (trigger),
    .busy               (busy),
    .overrun            (overrun),
    .spi_cnv            (spi_cnv),
    .spi_cs_n           (spi_cs_n),
    .spi_sclk           (spi_sclk),
    .spi_miso           (spi_miso),
    .m_axis_data_tdata  (tdata),
    .m_axis_data_tvalid (tvalid),
    .m_axis_data_tready (tready)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          seq_model = 0;
  int          beats = 0;
  int          ovr = 0;
  int          viol = 0;
  int          rise_cnt = 0;
  int          adc_idx = 0;
  logic [31:0] adc_word = 32'd0;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = 32'd0;

  // SPI ADC: MSB presented at chip-select fall, next bit after each SCLK rise.
  always @(negedge spi_cs_n or posedge spi_sclk) begin
    if (spi_sclk) begin
      rise_cnt++;
      if (adc_idx > 0) adc_idx--;
    end else begin
      adc_idx = DATA_BITS - 1;
    end
    spi_miso = adc_word[adc_idx];
  end

  // Stream monitor: beats, overrun pulses, hold-stability violations.
  always @(negedge aclk) begin
    if (!aresetn) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr && (!tvalid || tdata != pd)) viol++;
      if (tvalid && tready) beats++;
      if (overrun) ovr++;
      pv = tvalid;
      pr = tready;
      pd = tdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_beat(input logic [31:0] word);
    logic [63:0] v;
    logic [31:0] r;
    v = {32'd0, word} & ((64'd1 << DATA_BITS) - 64'd1);
    if (v[DATA_BITS-1]) v = v - (64'd1 << DATA_BITS);
    r = v[31:0];
`ifdef ADC_SPI_SEQ_EN
    r[31:24] = 8'(seq_model % 256);
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Returns just after the edge that samples the trigger.
  task automatic pulse_trig();
    tick();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 500) begin
      tick();
      k++;
    end
    if (busy) chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  // One conversion with tready expected high; extra_at>0 re-pulses trigger then.
  task automatic run_conv(input logic [31:0] word, input int extra_at);
    int          ncnv = 0;
    int          ncs = 0;
    int          lat = 0;
    int          r0;
    logic [31:0] got = 32'd0;
    adc_word = word;
    r0 = rise_cnt;
    pulse_trig();
    for (int k = 1; k <= LAT + 50 && lat == 0; k++) begin
      if (spi_cnv) ncnv++;
      if (!spi_cs_n) ncs++;
      if (tvalid) begin
        lat = k;
        got = tdata;
      end
      trigger = (k == extra_at);
      tick();
    end
    trigger = 1'b0;
    chk("cnv_cycles", ncnv, CONV_CYCLES);
    chk("cs_low_cycles", ncs, READ_CYC);
    chk("latency", lat, LAT);
    chk("sclk_rises", rise_cnt - r0, DATA_BITS);
    chk("tdata", got, exp_beat(word));
    seq_model++;
  endtask

  initial begin
    int          b0;
    int          o0;
    int          k;
    logic [31:0] w1;
    logic [31:0] e1;

    // Reset state
    tready = 1'b1;
    repeat (3) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);
    chk("rst_cnv", {31'd0, spi_cnv}, 32'd0);
    chk("rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    aresetn = 1'b1;
    repeat (20) tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Trigger with enable low is ignored
    pulse_trig();
    repeat (5) tick();
    chk("enable_gate", {31'd0, busy}, 32'd0);
    enable = 1'b1;

    // Negative full-scale style word, then positive word with stray trigger
    run_conv(32'h0080_0001, 0);
    b0 = beats;
    run_conv(32'h0001_2345, 80);
    repeat (300) tick();
    chk("one_beat", beats - b0, 1);
    chk("busy_after_stray", {31'd0, busy}, 32'd0);

    // Random words, no backpressure
    for (int i = 0; i < 6; i++) run_conv($urandom, 0);
    chk("no_overrun", ovr, 0);

    // Backpressure: second sample is dropped, first is held
    tready = 1'b0;
    o0 = ovr;
    b0 = beats;
    w1 = $urandom;
    adc_word = w1;
    pulse_trig();
    k = 1;
    while (!tvalid && k < 400) begin
      tick();
      k++;
    end
    e1 = exp_beat(w1);
    chk("bp_latency", k, LAT);
    chk("bp_first_data", tdata, e1);
    seq_model++;
    while (k < 159) begin
      tick();
      k++;
    end
    adc_word = $urandom;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    wait_idle();
    seq_model++;
    repeat (3) tick();
    chk("bp_overrun_once", ovr - o0, 1);
    chk("bp_held_valid", {31'd0, tvalid}, 32'd1);
    chk("bp_held_data", tdata, e1);
    chk("bp_no_beat_yet", beats - b0, 0);
    tready = 1'b1;
    repeat (50) tick();
    chk("bp_one_beat", beats - b0, 1);
    chk("bp_drained", {31'd0, tvalid}, 32'd0);

    // Reset in the middle of the read phase
    b0 = beats;
    adc_word = $urandom;
    pulse_trig();
    repeat (70) tick();
    chk("pre_rst_cs_n", {31'd0, spi_cs_n}, 32'd0);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_cs_n", {31'd0, spi_cs_n}, 32'd1);
    chk("mid_rst_sclk", {31'd0, spi_sclk}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    aresetn = 1'b1;
    seq_model = 0;
    repeat (200) tick();
    chk("rst_no_beat", beats - b0, 0);
    chk("rst_no_valid", {31'd0, tvalid}, 32'd0);
    run_conv($urandom, 0);

`ifdef ADC_SPI_SEQ_EN
    // Sequence number wraps through 255 back to 0
    for (int i = 0; i < 300; i++) run_conv($urandom, 0);
`endif

    chk("axis_stable", viol, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
